// File: rtl/ay_bus_responder.sv
// AY/YM PSG bus responder: resynchronises BDIR/BC1/data, decodes bus phases,
// keeps a masked shadow register file with readback, and queues writes as events.
module ay_bus_responder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       ay_bdir,
   input  logic       ay_bc1,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       dataout,
   output logic       evt_valid,
   output logic [3:0] evt_reg,
   output logic [7:0] evt_data,
   input  logic       evt_pop,
   output logic       evt_ovf,
   input  logic       evt_ovf_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'b00,
      PH_READ  = 2'b01,
      PH_WRITE = 2'b10,
      PH_LATCH = 2'b11
   } phase_t;

   function automatic logic [7:0] reg_mask(input logic [3:0] r);
      case (r)
         4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
         default:                 reg_mask = 8'hFF;
      endcase
   endfunction

   logic [1:0] ph_s1, ph_s2;
   logic [7:0] d_s1;
   phase_t     phase_q, phase_d;
   logic       act_latch, act_write;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         ph_s1 <= 2'b00;
         ph_s2 <= 2'b00;
         d_s1  <= 8'h00;
      end else begin
         ph_s1 <= {ay_bdir, ay_bc1};
         ph_s2 <= ph_s1;
         d_s1  <= din;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) phase_q <= PH_IDLE;
      else        phase_q <= phase_d;
   end

   // Stability is judged on the pair that shifts into the s2/s3 stages at this
   // edge, so the action registers on the same edge the last stage catches up.
   always_comb begin
      phase_d   = phase_q;
      act_latch = 1'b0;
      act_write = 1'b0;
      if ((ph_s1 == ph_s2) && (phase_t'(ph_s1) != phase_q)) begin
         phase_d   = phase_t'(ph_s1);
         act_latch = (phase_t'(ph_s1) == PH_LATCH);
         act_write = (phase_t'(ph_s1) == PH_WRITE);
      end
   end

   logic [7:0] regs [16];
   logic [3:0] addr;
   logic       addr_valid;
   logic [7:0] wr_data;

   assign wr_data = d_s1 & reg_mask(addr);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
         addr       <= 4'h0;
         addr_valid <= 1'b1;
      end else begin
         if (act_latch) begin
            addr_valid <= (d_s1[7:4] == 4'h0);
            addr       <= d_s1[3:0];
         end
         if (act_write && addr_valid) regs[addr] <= wr_data;
      end
   end

   // Idle bus reads as 0xFF; register data only appears during a read phase.
   assign dataout = (phase_q == PH_READ);
   assign dout    = (dataout && addr_valid) ? regs[addr] : 8'hFF;

   logic [11:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        push_req, fifo_full, fifo_empty, do_push, do_pop;

   assign push_req   = act_write && addr_valid;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop     = evt_pop && !fifo_empty;
   assign do_push    = push_req && (!fifo_full || do_pop);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 12'h000;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         evt_ovf <= 1'b0;
      end else begin
         if (do_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {addr, wr_data};
            wr_ptr                   <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         // A dropped push outranks a clear arriving on the same edge.
         if (push_req && !do_push) evt_ovf <= 1'b1;
         else if (evt_ovf_clr)     evt_ovf <= 1'b0;
      end
   end

   assign evt_valid           = !fifo_empty;
   assign {evt_reg, evt_data} = fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ay_bus_responder.sv
// Bench for ay_bus_responder: directed and random PSG bus cycles against a
// register/FIFO reference model, with a monitor checking events and readback.
module tb_ay_bus_responder;

   localparam int DEPTH = 4;

   logic       fclk = 1'b0;
   logic       rst_n;
   logic       ay_bdir, ay_bc1;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dataout;
   logic       evt_valid;
   logic [3:0] evt_reg;
   logic [7:0] evt_data;
   logic       evt_pop;
   logic       evt_ovf;
   logic       evt_ovf_clr;

   always #5 fclk = ~fclk;

   ay_bus_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .ay_bdir     (ay_bdir),
      .ay_bc1      (ay_bc1),
      .din         (din),
      .dout        (dout),
      .dataout     (dataout),
      .evt_valid   (evt_valid),
      .evt_reg     (evt_reg),
      .evt_data    (evt_data),
      .evt_pop     (evt_pop),
      .evt_ovf     (evt_ovf),
      .evt_ovf_clr (evt_ovf_clr)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  rd_q[$];
   bit          pop_en       = 1'b0;
   bit          pop_once     = 1'b0;
   bit          mdl_pop_same = 1'b0;
   bit          dv_prev      = 1'b0;

   logic [7:0]  mdl_reg [16];
   logic [7:0]  mask_tbl [16];
   logic [3:0]  mdl_addr;
   bit          mdl_av;
   bit          mdl_ovf;
   int          mdl_occ;
   int          m0f [4] = '{1, 3, 5, 13};
   int          m1f [4] = '{6, 8, 9, 10};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mdl_reset();
      foreach (mdl_reg[i]) mdl_reg[i] = 8'h00;
      mdl_addr = 4'h0;
      mdl_av   = 1'b1;
      mdl_ovf  = 1'b0;
      mdl_occ  = 0;
      pop_once = 1'b0;
      exp_q.delete();
      rd_q.delete();
   endtask

   task automatic mdl_fifo_push(input logic [11:0] ent);
      if (pop_en) exp_q.push_back(ent);
      else if (mdl_occ < DEPTH) begin
         exp_q.push_back(ent);
         mdl_occ++;
      end else if (mdl_pop_same) exp_q.push_back(ent);
      else mdl_ovf = 1'b1;
   endtask

   task automatic mdl_write(input logic [7:0] d);
      logic [7:0] v;
      if (mdl_av) begin
         v = d & mask_tbl[mdl_addr];
         mdl_reg[mdl_addr] = v;
         mdl_fifo_push({mdl_addr, v});
      end
   endtask

   // One PSG access: phase held long enough to commit, then an inactive gap.
   task automatic bus_op(input logic [1:0] ph, input logic [7:0] d,
                         input bit pop_act = 1'b0, input bit clr_act = 1'b0);
      @(negedge fclk);
      {ay_bdir, ay_bc1} = ph;
      din = d;
      @(posedge fclk);
      @(posedge fclk);
      #1;
      if (pop_act) pop_once = 1'b1;
      if (clr_act) evt_ovf_clr = 1'b1;
      @(posedge fclk);
      #1;
      evt_ovf_clr = 1'b0;
      repeat (2) @(posedge fclk);
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b00;
      repeat (3) @(posedge fclk);
   endtask

   task automatic do_latch(input logic [7:0] d);
      mdl_av   = (d[7:4] == 4'h0);
      mdl_addr = d[3:0];
      bus_op(2'b11, d);
   endtask

   task automatic do_write(input logic [7:0] d, input bit pop_act = 1'b0, input bit clr_act = 1'b0);
      mdl_write(d);
      bus_op(2'b10, d, pop_act, clr_act);
   endtask

   task automatic do_read();
      rd_q.push_back(mdl_av ? mdl_reg[mdl_addr] : 8'hFF);
      bus_op(2'b01, 8'($urandom_range(0, 255)));
   endtask

   task automatic glitch_write(input logic [7:0] d);
      mdl_write(d);
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b10;
      din = d;
      repeat (4) @(posedge fclk);
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b11;
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b10;
      repeat (4) @(posedge fclk);
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b00;
      repeat (3) @(posedge fclk);
   endtask

   task automatic clr_ovf();
      @(negedge fclk);
      evt_ovf_clr = 1'b1;
      @(negedge fclk);
      evt_ovf_clr = 1'b0;
      mdl_ovf = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || evt_valid) && t < 200) begin
         @(negedge fclk);
         t++;
      end
      check("drain_done", 32'(exp_q.size() == 0 && !evt_valid), 32'd1);
   endtask

   // Monitor: pops events and compares them, checks readback on each read entry.
   initial begin : monitor
      evt_pop = 1'b0;
      forever begin
         @(negedge fclk);
         evt_pop = 1'b0;
         if (rst_n) begin
            if (evt_valid && (pop_en || pop_once)) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL evt_unexpected: got %0h expected none", {evt_reg, evt_data});
               end else begin
                  check("evt_head", 32'({evt_reg, evt_data}), 32'(exp_q.pop_front()));
               end
               evt_pop  = 1'b1;
               pop_once = 1'b0;
            end
            if (dataout && !dv_prev) begin
               if (rd_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL read_unexpected: got dout %0h expected no read", dout);
               end else begin
                  check("read_dout", 32'(dout), 32'(rd_q.pop_front()));
               end
            end else if (!dataout) begin
               check("dout_idle", 32'(dout), 32'hFF);
            end
         end
         dv_prev = dataout;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      foreach (mask_tbl[i]) mask_tbl[i] = 8'hFF;
      foreach (m0f[j]) mask_tbl[m0f[j]] = 8'h0F;
      foreach (m1f[j]) mask_tbl[m1f[j]] = 8'h1F;

      rst_n = 1'b0;
      {ay_bdir, ay_bc1} = 2'b00;
      din = 8'h00;
      evt_ovf_clr = 1'b0;
      mdl_reset();
      repeat (3) @(posedge fclk);
      #1 rst_n = 1'b1;
      @(negedge fclk);
      check("rst_dout", 32'(dout), 32'hFF);
      check("rst_dataout", 32'(dataout), 32'd0);
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_reg", 32'(evt_reg), 32'd0);
      check("rst_evt_data", 32'(evt_data), 32'd0);
      check("rst_evt_ovf", 32'(evt_ovf), 32'd0);

      // Directed register, mask and invalid-address cases.
      pop_en = 1'b1;
      do_latch(8'h07); do_write(8'hFF); do_read();
      do_latch(8'h01); do_write(8'hAB); do_read();
      do_latch(8'h08); do_write(8'hFF); do_read();
      do_latch(8'h07); do_write(8'h5A);
      do_latch(8'h17); do_write(8'h55); do_read();
      do_latch(8'h07); do_read();

      // One-sample latch code inside a write must not latch or re-trigger.
      do_latch(8'h02);
      glitch_write(8'h05);
      do_read();

      // Overflow, pop-with-push when full, clear, and set-beats-clear.
      wait_drain();
      pop_en  = 1'b0;
      mdl_occ = 0;
      do_latch(8'h00);
      for (int i = 0; i < 5; i++) do_write(8'($urandom_range(0, 255)));
      @(negedge fclk);
      check("full_evt_valid", 32'(evt_valid), 32'd1);
      check("ovf_set", 32'(evt_ovf), 32'(mdl_ovf));
      clr_ovf();
      @(negedge fclk);
      check("ovf_clr", 32'(evt_ovf), 32'(mdl_ovf));
      mdl_pop_same = 1'b1;
      do_write(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      mdl_pop_same = 1'b0;
      @(negedge fclk);
      check("pop_push_no_ovf", 32'(evt_ovf), 32'(mdl_ovf));
      do_write(8'($urandom_range(0, 255)), 1'b0, 1'b1);
      @(negedge fclk);
      check("ovf_set_wins", 32'(evt_ovf), 32'(mdl_ovf));
      clr_ovf();
      @(negedge fclk);
      check("ovf_clr2", 32'(evt_ovf), 32'd0);
      pop_en = 1'b1;
      wait_drain();

      // Fill and overflow, then reset during a write.
      pop_en  = 1'b0;
      mdl_occ = 0;
      do_latch(8'h04);
      for (int i = 0; i < 5; i++) do_write(8'($urandom_range(0, 255)));
      @(negedge fclk);
      {ay_bdir, ay_bc1} = 2'b10;
      din = 8'h77;
      @(posedge fclk);
      #1;
      rst_n = 1'b0;
      {ay_bdir, ay_bc1} = 2'b00;
      mdl_reset();
      @(posedge fclk);
      #1 rst_n = 1'b1;
      @(negedge fclk);
      check("mrst_evt_valid", 32'(evt_valid), 32'd0);
      check("mrst_evt_ovf", 32'(evt_ovf), 32'd0);
      check("mrst_evt_reg", 32'(evt_reg), 32'd0);
      check("mrst_evt_data", 32'(evt_data), 32'd0);
      check("mrst_dataout", 32'(dataout), 32'd0);
      pop_en = 1'b1;
      do_latch(8'h04); do_read();
      do_latch(8'h00); do_read();

      // Randomised mix against the model.
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0: do_latch(($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                                    : 8'($urandom_range(0, 15)));
            1: do_write(8'($urandom_range(0, 255)));
            default: do_read();
         endcase
      end

      wait_drain();
      check("reads_consumed", 32'(rd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
